// File: rtl/pwm_compare.sv
// pwm_compare: compares a free-running count against a double-buffered duty
// value and drives a registered PWM output and a once-per-period done strobe.
// Duty updates use a valid/ready handshake into a shadow register. The shadow
// value is applied only at a period start (count == 0).
// Optional feature macro: PWM_DEADBAND_EN adds a complementary output pwm_lo,
// parameter DEADBAND, and dead-time insertion on both outputs.
module pwm_compare #(
    parameter int N = 4
`ifdef PWM_DEADBAND_EN
    ,
    parameter int DEADBAND = 2
`endif
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic [N-1:0] count,
    input  logic         enable,
    input  logic [N:0]   duty_in,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         pwm,
    output logic         period_done
`ifdef PWM_DEADBAND_EN
    ,
    output logic         pwm_lo
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [N:0] active_duty;
    logic [N:0] shadow;
    logic       pending;

    logic       period_start;
    logic       load;
    logic       xfer;
    logic [N:0] duty_eff;
    logic       raw_hi;
    logic       last_count;

    // The shadow register is free whenever nothing is waiting to be applied.
    assign duty_ready = !pending;
    assign xfer       = duty_valid && !pending;
    assign last_count = (count == {N{1'b1}});

    // Next-state logic: enable low forces IDLE from any state.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ARM;
                ARM:     if (count == '0) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Period-start detection, shadow load and the compare itself.
    always_comb begin
        period_start = enable && ((state == ARM) || (state == RUN)) && (count == '0);
        load         = period_start && pending;
        duty_eff     = load ? shadow : active_duty;
        // Comparing in N+1 bits makes any duty >= 2**N saturate to "always high".
        raw_hi       = (state_next == RUN) && ({1'b0, count} < duty_eff);
    end

    // State, duty buffers and handshake bookkeeping.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            active_duty <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (load) begin
                active_duty <= shadow;
            end
            // A load requires pending=1, which blocks a transfer in the same
            // cycle, so a transfer at a period start only ever fills the shadow.
            if (xfer) begin
                shadow  <= duty_in;
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
        end
    end

    // One strobe on the last count of each RUN period (never while arming).
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            period_done <= 1'b0;
        end else begin
            period_done <= (state == RUN) && last_count;
        end
    end

`ifdef PWM_DEADBAND_EN
    // Run-length counters saturate at DEADBAND; width holds 0..DEADBAND.
    localparam int DB_W = $clog2(DEADBAND + 2);
    localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEADBAND);

    logic            raw_lo;
    logic [DB_W-1:0] hi_run;
    logic [DB_W-1:0] lo_run;

    assign raw_lo = (state_next == RUN) && !raw_hi;

    // Each output rises only after its raw request has been present for
    // DEADBAND cycles; falls pass straight through, so both sides are low
    // during the gap and pulses no longer than DEADBAND are swallowed.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            hi_run <= '0;
            lo_run <= '0;
            pwm    <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            if (raw_hi) begin
                hi_run <= (hi_run < DB_LIM) ? hi_run + DB_W'(1) : hi_run;
            end else begin
                hi_run <= '0;
            end
            if (raw_lo) begin
                lo_run <= (lo_run < DB_LIM) ? lo_run + DB_W'(1) : lo_run;
            end else begin
                lo_run <= '0;
            end
            pwm    <= raw_hi && (hi_run >= DB_LIM);
            pwm_lo <= raw_lo && (lo_run >= DB_LIM);
        end
    end
`else
    // Plain registered compare output.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= raw_hi;
        end
    end
`endif

endmodule
